// File: rtl/vector_pkg.sv
// Shared vector-unit types: reduction ops, reducer FSM states and default
// lane geometry used by both the vector ALU and the lane reducer.
package vector_pkg;

  localparam int unsigned VEC_DATA_WIDTH = 19;
  localparam int unsigned VEC_LANES      = 6;

  typedef enum logic [1:0] {
    OP_SUM  = 2'b00,
    OP_MAX  = 2'b01,
    OP_MIN  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_e;

endpackage

// File: rtl/vector_lane_reducer_if.sv
// Input vector handshake and output scalar handshake of the lane reducer.
interface vector_lane_reducer_if
  import vector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = VEC_DATA_WIDTH,
  parameter int unsigned LANES      = VEC_LANES,
  parameter int unsigned ACC_WIDTH  = DATA_WIDTH + $clog2(LANES)
) ();

  logic                              in_valid;
  logic                              in_ready;
  logic [LANES-1:0][DATA_WIDTH-1:0]  operand;
  logic [LANES-1:0]                  lane_mask;
  op_e                               op;
  logic                              out_valid;
  logic                              out_ready;
  logic [ACC_WIDTH-1:0]              result;
  logic                              N;
  logic                              Z;
  logic                              V;
  logic                              E;

  modport master (
    output in_valid, operand, lane_mask, op, out_ready,
    input  in_ready, out_valid, result, N, Z, V, E
  );

  modport slave (
    input  in_valid, operand, lane_mask, op, out_ready,
    output in_ready, out_valid, result, N, Z, V, E
  );

endinterface

// File: rtl/lane_combine.sv
// Combines one sign-extended lane into the running accumulator (SUM/MAX/MIN).
module lane_combine
  import vector_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = VEC_DATA_WIDTH + $clog2(VEC_LANES)
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic signed [ACC_WIDTH-1:0] lane,
  input  op_e                         op,
  input  logic                        seen,
  output logic signed [ACC_WIDTH-1:0] acc_nxt
);

  always_comb begin
    acc_nxt = acc + lane;
    case (op)
      // The first enabled lane seeds MAX/MIN so the cleared accumulator never wins.
      OP_MAX:  acc_nxt = (!seen || (lane > acc)) ? lane : acc;
      OP_MIN:  acc_nxt = (!seen || (lane < acc)) ? lane : acc;
      default: acc_nxt = acc + lane;
    endcase
  end

endmodule

// File: rtl/vector_lane_reducer.sv
// Lane-serial horizontal reducer: one lane per cycle, registered scalar result
// and N/Z/V/E flags presented through a valid/ready output handshake.
module vector_lane_reducer
  import vector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = VEC_DATA_WIDTH,
  parameter int unsigned LANES      = VEC_LANES,
  parameter int unsigned ACC_WIDTH  = DATA_WIDTH + $clog2(LANES)
) (
  input logic                   clk,
  input logic                   rst_n,
  vector_lane_reducer_if.slave  bus
);

  localparam int unsigned IDXW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(LANES - 1);

  state_e                           state;
  logic [IDXW-1:0]                  idx;
  logic signed [ACC_WIDTH-1:0]      acc;
  logic                             seen;
  logic [LANES-1:0][DATA_WIDTH-1:0] cap_operand;
  logic [LANES-1:0]                 cap_mask;
  op_e                              cap_op;
  logic [ACC_WIDTH-1:0]             result_q;
  logic                             n_q, z_q, v_q, e_q;

  logic signed [DATA_WIDTH-1:0]     lane_s;
  logic signed [ACC_WIDTH-1:0]      lane_ext;
  logic signed [ACC_WIDTH-1:0]      acc_nxt;
  logic signed [ACC_WIDTH-1:0]      acc_fin;
  logic [ACC_WIDTH-DATA_WIDTH:0]    acc_hi;

  assign lane_s   = cap_operand[idx];
  assign lane_ext = ACC_WIDTH'(lane_s);

  lane_combine #(.ACC_WIDTH(ACC_WIDTH)) u_combine (
    .acc     (acc),
    .lane    (lane_ext),
    .op      (cap_op),
    .seen    (seen),
    .acc_nxt (acc_nxt)
  );

  // Value the accumulator takes on the last lane; flags are registered from it.
  assign acc_fin = cap_mask[idx] ? acc_nxt : acc;
  assign acc_hi  = acc_fin[ACC_WIDTH-1:DATA_WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      acc         <= '0;
      seen        <= 1'b0;
      cap_operand <= '0;
      cap_mask    <= '0;
      cap_op      <= OP_SUM;
      result_q    <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      e_q         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            cap_operand <= bus.operand;
            cap_mask    <= bus.lane_mask;
            cap_op      <= bus.op;
            acc         <= '0;
            idx         <= '0;
            seen        <= 1'b0;
            state       <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (cap_mask[idx]) begin
            acc  <= acc_nxt;
            seen <= 1'b1;
          end
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            result_q <= acc_fin;
            n_q      <= acc_fin[ACC_WIDTH-1];
            z_q      <= (acc_fin == '0);
            v_q      <= !((&acc_hi) || !(|acc_hi));
            e_q      <= (cap_mask == '0);
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = result_q;
  assign bus.N         = n_q;
  assign bus.Z         = z_q;
  assign bus.V         = v_q;
  assign bus.E         = e_q;

endmodule

// File: tb/tb_vector_lane_reducer.sv
// Directed self-checking bench for vector_lane_reducer at default geometry.
module tb_vector_lane_reducer;
  import vector_pkg::*;

  localparam int unsigned DW = 19;
  localparam int unsigned LN = 6;

  typedef logic [LN-1:0][DW-1:0] vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  vector_lane_reducer_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

  vector_lane_reducer #(.DATA_WIDTH(DW), .LANES(LN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(input int a0, input int a1, input int a2,
                              input int a3, input int a4, input int a5);
    vec_t v;
    v[0] = a0[DW-1:0];
    v[1] = a1[DW-1:0];
    v[2] = a2[DW-1:0];
    v[3] = a3[DW-1:0];
    v[4] = a4[DW-1:0];
    v[5] = a5[DW-1:0];
    return v;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic start(input op_e o, input logic [LN-1:0] m, input vec_t v);
    int k;
    k = 0;
    while (!bus.in_ready && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 30) chk("ready_timeout", 0, 1);
    bus.in_valid  = 1'b1;
    bus.op        = o;
    bus.lane_mask = m;
    bus.operand   = v;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.out_valid && lat < 30);
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic chk_out(input string tag, input int res,
                         input int n, input int z, input int v, input int e);
    chk({tag, "_res"}, int'($signed(bus.result)), res);
    chk({tag, "_nzve"}, int'({bus.N, bus.Z, bus.V, bus.E}),
        int'({n[0], z[0], v[0], e[0]}));
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_hs"}, int'({bus.in_ready, bus.out_valid}), 2);
  endtask

  task automatic txn(input string tag, input op_e o, input logic [LN-1:0] m,
                     input vec_t v, input int res,
                     input int n, input int z, input int vf, input int e);
    start(o, m, v);
    wait_out(tag, 6);
    chk_out(tag, res, n, z, vf, e);
    handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.operand   = '0;
    bus.lane_mask = '0;
    bus.op        = OP_SUM;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy_vld", int'({bus.in_ready, bus.out_valid}), 2);
    chk_out("rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    txn("sum16", OP_SUM, 6'b111111, mk(1, 2, 3, 4, 5, 6), 21, 0, 0, 0, 0);
    txn("max", OP_MAX, 6'b110111, mk(-3, 7, -100, 7, 0, 2), 7, 0, 0, 0, 0);
    txn("min", OP_MIN, 6'b110111, mk(-3, 7, -100, 7, 0, 2), -100, 1, 0, 0, 0);
    txn("maxmask", OP_MAX, 6'b110111, mk(-3, 7, -100, 50, 0, 2), 7, 0, 0, 0, 0);
    txn("maxneg1", OP_MAX, 6'b010000, mk(9, 9, 9, 9, -5, 9), -5, 1, 0, 0, 0);
    txn("rsvd", OP_RSVD, 6'b111111, mk(1, 2, 3, 4, 5, 6), 21, 0, 0, 0, 0);
    txn("sumovp", OP_SUM, 6'b111111,
        mk(262143, 262143, 262143, 262143, 262143, 262143), 1572858, 0, 0, 1, 0);
    txn("sumovn", OP_SUM, 6'b111111,
        mk(-262144, -262144, -262144, -262144, -262144, -262144), -1572864, 1, 0, 1, 0);
    txn("emptysum", OP_SUM, 6'b000000, mk(5, 6, 7, 8, 9, 10), 0, 0, 1, 0, 1);
    txn("emptymax", OP_MAX, 6'b000000, mk(5, 6, 7, 8, 9, 10), 0, 0, 1, 0, 1);

    // Back-pressure with in_valid held during ACCUM/DONE carrying other data.
    start(OP_SUM, 6'b111111, mk(10, -20, 30, -40, 50, -60));
    bus.in_valid  = 1'b1;
    bus.op        = OP_MAX;
    bus.lane_mask = 6'b111111;
    bus.operand   = mk(100, 100, 100, 100, 100, 100);
    wait_out("bp", 6);
    chk_out("bp", -30, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_res", int'($signed(bus.result)), -30);
      chk("bp_hold_rdy_vld", int'({bus.in_ready, bus.out_valid}), 1);
    end
    bus.op        = OP_SUM;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_after_hs", int'({bus.in_ready, bus.out_valid}), 2);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_accept_next", int'(bus.in_ready), 0);
    wait_out("bp2", 6);
    chk_out("bp2", 600, 0, 0, 0, 0);

    // Asynchronous reset while lane 3 is pending, with a stale result held.
    handshake("bp2");
    start(OP_SUM, 6'b111111, mk(5, 5, 5, 5, 5, 5));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_rdy_vld", int'({bus.in_ready, bus.out_valid}), 2);
    chk_out("arst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_ready", int'(bus.in_ready), 1);
    txn("post_rst", OP_SUM, 6'b111111, mk(1, 1, 1, 1, 1, 1), 6, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
